mem_bus_arbiter: RTL

//  Round-robin arbiter sharing the single valid/ready native memory bus (BRAM, LED, UART decode) between two masters.
//  m0 = CPU, m1 = loader/DMA master. One transaction per grant.

---
 rtl/mem_bus_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that lets a CPU (m0) and a loader/DMA master (m1) share one
// valid/ready memory bus. Each grant carries exactly one transaction, followed by a
// one-cycle gap. A watchdog completes hung transactions with an error word.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (CPU)
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  // master 1 (loader/DMA)
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  // shared slave bus
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  // status
  output logic [1:0]  grant,
  output logic        timeout_err
);

  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StGap} state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;    // 1: m1 received the most recent grant
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           terr_q, terr_d;

  logic           wd_hit;
  logic           own_sel;           // 1: m1 is the current owner
  logic           own_valid;
  logic           own_ready;
  logic [31:0]    own_rdata;

  // A TIMEOUT of zero disables the watchdog entirely.
  assign wd_hit    = (TIMEOUT != 0) && (wdog_q == WdW'(TIMEOUT - 1));
  assign own_sel   = (state_q == StOwn1);
  assign own_valid = own_sel ? m1_valid : m0_valid;

  assign timeout_err = terr_q;

  // Route the owner's response back; the non-owner always sees zeros.
  assign m0_ready = own_ready && (state_q == StOwn0);
  assign m1_ready = own_ready && (state_q == StOwn1);
  assign m0_rdata = (state_q == StOwn0) ? own_rdata : '0;
  assign m1_rdata = (state_q == StOwn1) ? own_rdata : '0;

  // Next-state, arbitration, watchdog and slave-side outputs.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    terr_d    = terr_q;
    grant     = 2'b00;
    s_valid   = 1'b0;
    s_instr   = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    own_ready = 1'b0;
    own_rdata = '0;

    unique case (state_q)
      StIdle: begin
        // m0 wins when it is alone or when m1 had the last grant.
        if (m0_valid && (!m1_valid || last_q)) begin
          state_d = StOwn0;
          last_d  = 1'b0;
          wdog_d  = '0;
        end else if (m1_valid) begin
          state_d = StOwn1;
          last_d  = 1'b1;
          wdog_d  = '0;
        end
      end

      StOwn0, StOwn1: begin
        grant     = own_sel ? 2'b10 : 2'b01;
        s_instr   = own_sel ? m1_instr : m0_instr;
        s_addr    = own_sel ? m1_addr  : m0_addr;
        s_wdata   = own_sel ? m1_wdata : m0_wdata;
        s_wstrb   = own_sel ? m1_wstrb : m0_wstrb;
        own_rdata = s_rdata;
        if (!own_valid) begin
          // Owner withdrew its request: release the bus without a response.
          state_d = StGap;
        end else if (s_ready) begin
          // Real completion takes priority over a coincident timeout.
          s_valid   = 1'b1;
          own_ready = 1'b1;
          state_d   = StGap;
        end else if (wd_hit) begin
          own_ready = 1'b1;
          own_rdata = ERR_DATA;
          terr_d    = 1'b1;
          state_d   = StGap;
        end else begin
          s_valid = 1'b1;
          wdog_d  = wdog_q + WdW'(1);
        end
      end

      // Masters still hold valid here; skipping arbitration avoids a stale re-grant.
      StGap: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      terr_q  <= terr_d;
    end
  end

endmodule
